smart_intersection_ctrl: RTL and testbench
==========================================

Name: smart_intersection_ctrl

Overview:
- Parametrised N-approach successor to the single-approach smart traffic light.
- Holds one saturating car-queue counter per approach and grants green by round-robin among approaches that have cars queued.
- Green duration is queue-driven, with minimum and maximum bounds.
- Supports per-approach emergency pre-emption with a safe yellow / all-red handover.
- Sits between the vehicle-detector front end and the lamp drivers.

Parameters:
- NUM_APPR, 4, number of approaches (2..8).
- QW, 4, queue counter width; saturates at 2^QW-1.
- TW, 5, phase timer width.
- GREEN_MIN, 4, minimum normal green in cycles.
- GREEN_MAX, 12, maximum normal green in cycles when another approach is waiting (GREEN_MIN <= GREEN_MAX < 2^TW).
- YELLOW_T, 2, yellow duration in cycles (>=1).
- ALLRED_T, 1, all-red clearance in cycles (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- car_detected, input, NUM_APPR, bit i=1 means one car arrives at approach i this cycle.
- emergency, input, NUM_APPR, level request for pre-emption of approach i.
- lights, output, 3*NUM_APPR, per-approach lamps; slice [3i+2:3i] = {Red,Yellow,Green}.
- queue_count, output, QW*NUM_APPR, per-approach queue; slice [QW*i+QW-1:QW*i].
- active_appr, output, clog2(NUM_APPR), approach currently owning the phase.
- preempt_active, output, 1, high in any pre-emption state.

Behaviour:
- Registered outputs only. Every output is decoded from registered state, updating one cycle after the deciding edge.
- Reset (rst=0, asynchronous):
  - state=ALL_RED, timer=0, active_appr=0, all queues=0, preempt_active=0.
  - Every lights slice = 3'b100.
  - Release of reset is synchronous to clk.
- States:
  - GREEN: active approach = 001; others = 100.
  - YELLOW: active approach = 010; others = 100.
  - ALL_RED: all approaches = 100.
  - EM_GREEN: emergency approach = 001; others = 100.
- Timer: reset to 0 on every state entry; increments each cycle; saturates at 2^TW-1.
- ALL_RED to GREEN:
  - Transition when timer==ALLRED_T-1.
  - Next approach = first index after active_appr (wrapping) with queue>0.
  - If no queue is non-zero, next approach = active_appr+1 mod NUM_APPR.
  - On the first exit after reset, the approach is 0.
- GREEN to YELLOW: only if some other approach has queue>0, and either condition holds:
  - timer>=GREEN_MIN-1 and the own queue is 0, or
  - timer>=GREEN_MAX-1.
  - If no other approach is waiting, hold green indefinitely (rest-on-green).
- YELLOW to ALL_RED when timer==YELLOW_T-1.
- Queue update:
  - +1 on car_detected[i].
  - -1 when i is green (GREEN or EM_GREEN) and the queue is >0.
  - Both in the same cycle: unchanged.
  - Saturate at max; never underflow. No decrement during YELLOW or ALL_RED.
- Emergency selection: target e = lowest index with emergency set.
- Emergency while in GREEN:
  - If e==active_appr, go to EM_GREEN next cycle, skipping yellow; active_appr unchanged.
  - Otherwise go to YELLOW next cycle, ignoring GREEN_MIN; latch pending target e.
- Emergency while in YELLOW or ALL_RED: finish the current yellow and all-red timing, then enter EM_GREEN for the latched or current e.
- Pre-emption handover:
  - On entering EM_GREEN, active_appr=e and preempt_active=1.
  - preempt_active stays high through the subsequent YELLOW and ALL_RED.
- EM_GREEN hold and exit:
  - Hold while emergency[e]=1; no timer limit.
  - On release: go to YELLOW, then ALL_RED, then normal round-robin from e.
  - Exit applies even if another emergency bit is set; that request is served via the normal YELLOW/ALL_RED path on the next arbitration.
- Emergency request dropped before EM_GREEN: pending is cleared at ALL_RED exit, and normal arbitration applies.
- Safety invariant: at most one approach has its Green or Yellow bit set in any cycle. Every change of owner passes through at least ALLRED_T all-red cycles.

Decomposition:
- Package smart_traffic_pkg holds:
  - State encoding constants ST_GREEN, ST_YELLOW, ST_ALL_RED, ST_EM_GREEN.
  - Lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- One sub-module: appr_queue_counter (QW parameter; inc, dec_en, count), instantiated NUM_APPR times via generate.
- Round-robin pick and lowest-index emergency pick remain combinational logic in the top module.

Test Plan:
- Reset: hold rst=0 mid-GREEN -> all lights=12'h924 (NUM_APPR=4), queues=0, active_appr=0 immediately (asynchronous); after release, ALL_RED for 1 cycle, then approach 0 green.
- Round-robin: pulse car_detected=4'b1010 once, no further arrivals -> green on approach 1.
  - Approach 1 drains to 0; yellow starts at timer 3 (GREEN_MIN).
  - Yellow lasts 2 cycles, all-red 1 cycle, then approach 3 green.
- Max green: approach 0 green; car_detected[0]=1 continuously and one pulse on approach 2 -> yellow after exactly 12 green cycles, then approach 2 green.
- Saturation and simultaneity: 20 consecutive arrivals on a red approach -> queue=15 and stays at 15. An arrival coinciding with a departure on the green approach -> queue unchanged.
- Pre-emption, other approach: approach 0 green at timer 1, emergency=4'b0100 -> yellow next cycle (GREEN_MIN ignored); preempt_active=1.
  - After yellow and all-red, approach 2 is EM_GREEN while the request holds.
  - On release, yellow/all-red, then round-robin from 2.
- Pre-emption, current approach and conflicts: emergency[active]=1 during GREEN -> EM_GREEN next cycle with no yellow.
  - emergency=4'b0110 -> approach 1 is served first.
  - Dropping the request during ALL_RED -> no EM_GREEN; normal arbitration.

Source files
------------

// File: rtl/smart_traffic_pkg.sv
// Shared state encoding and lamp patterns for the intersection controller.
package smart_traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN    = 2'd0,
    ST_YELLOW   = 2'd1,
    ST_ALL_RED  = 2'd2,
    ST_EM_GREEN = 2'd3
  } state_e;

  // Lamp slice order is {Red, Yellow, Green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/appr_queue_counter.sv
// Per-approach saturating car queue: +1 on arrival, -1 on departure while green.
module appr_queue_counter #(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec_en,
  output logic [QW-1:0] count
);

  localparam logic [QW-1:0] Q_MAX = '1;

  logic dec;

  // A departure needs a car in the queue; an empty green lane never underflows.
  assign dec = dec_en && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  count <= '0;
    else if (inc && !dec && (count != Q_MAX))  count <= count + 1'b1;
    else if (dec && !inc)                      count <= count - 1'b1;
  end

endmodule

// File: rtl/smart_intersection_ctrl.sv
// N-approach intersection: queue-driven round-robin green with emergency
// pre-emption and a yellow / all-red handover on every change of owner.
module smart_intersection_ctrl
  import smart_traffic_pkg::*;
#(
  parameter int NUM_APPR  = 4,
  parameter int QW        = 4,
  parameter int TW        = 5,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_APPR-1:0]           car_detected,
  input  logic [NUM_APPR-1:0]           emergency,
  output logic [3*NUM_APPR-1:0]         lights,
  output logic [QW*NUM_APPR-1:0]        queue_count,
  output logic [$clog2(NUM_APPR)-1:0]   active_appr,
  output logic                          preempt_active
);

  localparam int AW = $clog2(NUM_APPR);
  localparam logic [TW-1:0] T_MAX = '1;

  state_e          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [AW-1:0]   act_nxt, pend_idx, pend_nxt, rr_idx, e_idx, em_tgt;
  logic            preempt_nxt, pend_vld, pend_vld_nxt, boot, boot_nxt;
  logic            others_wait, own_empty, e_any;
  logic [NUM_APPR-1:0] q_nz, dec_en;

  generate
    for (genvar i = 0; i < NUM_APPR; i++) begin : g_q
      appr_queue_counter #(.QW(QW)) u_q (
        .clk    (clk),
        .rst    (rst),
        .inc    (car_detected[i]),
        .dec_en (dec_en[i]),
        .count  (queue_count[QW*i +: QW])
      );
      assign q_nz[i]   = |queue_count[QW*i +: QW];
      assign dec_en[i] = ((state == ST_GREEN) || (state == ST_EM_GREEN)) &&
                         (active_appr == AW'(i));
    end
  endgenerate

  // Lowest-index emergency target and round-robin successor of the owner.
  always_comb begin
    e_any = |emergency;
    e_idx = '0;
    for (int i = NUM_APPR - 1; i >= 0; i--)
      if (emergency[i]) e_idx = AW'(i);
    rr_idx = AW'((int'(active_appr) + 1) % NUM_APPR);
    // Scan downward so the nearest waiting approach after the owner wins.
    for (int k = NUM_APPR; k >= 1; k--)
      if (q_nz[AW'((int'(active_appr) + k) % NUM_APPR)])
        rr_idx = AW'((int'(active_appr) + k) % NUM_APPR);
    others_wait = |(q_nz & ~(NUM_APPR'(1) << active_appr));
    own_empty   = !q_nz[active_appr];
    em_tgt      = (pend_vld && emergency[pend_idx]) ? pend_idx : e_idx;
  end

  always_comb begin
    state_nxt    = state;
    act_nxt      = active_appr;
    preempt_nxt  = preempt_active;
    pend_vld_nxt = pend_vld;
    pend_nxt     = pend_idx;
    boot_nxt     = boot;
    case (state)
      ST_GREEN: begin
        if (e_any) begin
          preempt_nxt = 1'b1;
          if (e_idx == active_appr) begin
            state_nxt = ST_EM_GREEN;
          end else begin
            state_nxt    = ST_YELLOW;
            pend_vld_nxt = 1'b1;
            pend_nxt     = e_idx;
          end
        end else if (others_wait &&
                     (((timer >= TW'(GREEN_MIN - 1)) && own_empty) ||
                      (timer >= TW'(GREEN_MAX - 1)))) begin
          state_nxt = ST_YELLOW;
        end
      end
      ST_YELLOW: if (timer == TW'(YELLOW_T - 1)) state_nxt = ST_ALL_RED;
      ST_ALL_RED: begin
        if (timer == TW'(ALLRED_T - 1)) begin
          boot_nxt     = 1'b0;
          pend_vld_nxt = 1'b0;
          if (e_any) begin
            state_nxt   = ST_EM_GREEN;
            act_nxt     = em_tgt;
            preempt_nxt = 1'b1;
          end else begin
            state_nxt   = ST_GREEN;
            act_nxt     = boot ? '0 : rr_idx;
            preempt_nxt = 1'b0;
          end
        end
      end
      ST_EM_GREEN: if (!emergency[active_appr]) state_nxt = ST_YELLOW;
      default: state_nxt = ST_ALL_RED;
    endcase
    timer_nxt = (state_nxt != state) ? '0 :
                (timer == T_MAX)     ? timer : timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_ALL_RED;
      timer          <= '0;
      active_appr    <= '0;
      preempt_active <= 1'b0;
      pend_vld       <= 1'b0;
      pend_idx       <= '0;
      boot           <= 1'b1;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      active_appr    <= act_nxt;
      preempt_active <= preempt_nxt;
      pend_vld       <= pend_vld_nxt;
      pend_idx       <= pend_nxt;
      boot           <= boot_nxt;
    end
  end

  always_comb begin
    lights = {NUM_APPR{LAMP_RED}};
    for (int i = 0; i < NUM_APPR; i++) begin
      if (AW'(i) == active_appr) begin
        if ((state == ST_GREEN) || (state == ST_EM_GREEN)) lights[3*i +: 3] = LAMP_GRN;
        else if (state == ST_YELLOW)                       lights[3*i +: 3] = LAMP_YEL;
      end
    end
  end

endmodule

// File: tb/tb_smart_intersection_ctrl.sv
// Directed bench for smart_intersection_ctrl (4 approaches) with a per-cycle
// scoreboard against a behavioural model plus hand-derived checkpoints.
module tb_smart_intersection_ctrl;

  localparam int ALLRED_T = 1, YELLOW_T = 2, GREEN_MIN = 4, GREEN_MAX = 12;
  localparam int M_G = 0, M_Y = 1, M_AR = 2, M_EM = 3;

  logic        clk, rst;
  logic [3:0]  car_detected, emergency;
  logic [11:0] lights;
  logic [15:0] queue_count;
  logic [1:0]  active_appr;
  logic        preempt_active;

  smart_intersection_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .car_detected   (car_detected),
    .emergency      (emergency),
    .lights         (lights),
    .queue_count    (queue_count),
    .active_appr    (active_appr),
    .preempt_active (preempt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] lights;
    logic [15:0] q;
    logic [1:0]  act;
    logic        pre;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_st, m_tim, m_act, m_pend;
  int m_q[4];
  bit m_pre, m_pv, m_boot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = M_AR; m_tim = 0; m_act = 0; m_pend = 0;
    m_pre = 0; m_pv = 0; m_boot = 1;
    for (int i = 0; i < 4; i++) m_q[i] = 0;
  endtask

  function automatic exp_t m_out();
    exp_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == m_act && (m_st == M_G || m_st == M_EM)) r.lights[3*i +: 3] = 3'b001;
      else if (i == m_act && m_st == M_Y)              r.lights[3*i +: 3] = 3'b010;
      else                                             r.lights[3*i +: 3] = 3'b100;
      r.q[4*i +: 4] = 4'(m_q[i]);
    end
    r.act = 2'(m_act);
    r.pre = m_pre;
    return r;
  endfunction

  // One clock of the intersection as described in prose: arbitration, then queues.
  task automatic model_step(input logic [3:0] car, input logic [3:0] em);
    int ns, na, nt, e;
    int nq[4];
    bit e_any, own_z, oth, grn, dep;
    e_any = (em != 4'b0);
    e = 0;
    for (int i = 3; i >= 0; i--) if (em[i]) e = i;
    own_z = (m_q[m_act] == 0);
    oth = 0;
    for (int i = 0; i < 4; i++) if (i != m_act && m_q[i] > 0) oth = 1;
    ns = m_st; na = m_act;
    case (m_st)
      M_G: begin
        if (e_any) begin
          m_pre = 1;
          if (e == m_act) ns = M_EM;
          else begin ns = M_Y; m_pv = 1; m_pend = e; end
        end else if (oth && ((m_tim >= GREEN_MIN - 1 && own_z) || m_tim >= GREEN_MAX - 1))
          ns = M_Y;
      end
      M_Y: if (m_tim == YELLOW_T - 1) ns = M_AR;
      M_AR: if (m_tim == ALLRED_T - 1) begin
        if (e_any) begin
          ns = M_EM; m_pre = 1;
          na = (m_pv && em[m_pend]) ? m_pend : e;
        end else begin
          ns = M_G; m_pre = 0;
          if (m_boot) na = 0;
          else begin
            na = (m_act + 1) % 4;
            for (int k = 4; k >= 1; k--) if (m_q[(m_act + k) % 4] > 0) na = (m_act + k) % 4;
          end
        end
        m_pv = 0; m_boot = 0;
      end
      default: if (!em[m_act]) ns = M_Y;
    endcase
    for (int i = 0; i < 4; i++) begin
      grn = (m_st == M_G || m_st == M_EM) && (m_act == i);
      dep = grn && (m_q[i] > 0);
      nq[i] = m_q[i];
      if (car[i] && !dep && m_q[i] < 15) nq[i] = m_q[i] + 1;
      else if (dep && !car[i])           nq[i] = m_q[i] - 1;
    end
    nt = (ns != m_st) ? 0 : ((m_tim == 31) ? 31 : m_tim + 1);
    m_st = ns; m_act = na; m_tim = nt;
    for (int i = 0; i < 4; i++) m_q[i] = nq[i];
  endtask

  // Drive one cycle, queue the model's prediction, compare after the edge.
  task automatic cycle(input logic [3:0] car, input logic [3:0] em);
    exp_t e;
    car_detected = car;
    emergency    = em;
    model_step(car, em);
    sb.push_back(m_out());
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("sb_lights",  32'(lights),         32'(e.lights));
    chk("sb_queues",  32'(queue_count),    32'(e.q));
    chk("sb_active",  32'(active_appr),    32'(e.act));
    chk("sb_preempt", 32'(preempt_active), 32'(e.pre));
  endtask

  initial begin
    int n;
    rst = 1'b1; car_detected = '0; emergency = '0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_lights",  32'(lights), 32'h924);
    chk("reset_queues",  32'(queue_count), 32'h0);
    chk("reset_active",  32'(active_appr), 32'h0);
    chk("reset_preempt", 32'(preempt_active), 32'h0);
    @(negedge clk) rst = 1'b1;
    cycle(4'b0000, 4'b0000);
    chk("boot_green0", 32'(lights), 32'h921);
    repeat (4) cycle(4'b0000, 4'b0000);

    // Round-robin: arrivals on 1 and 3; 1 holds for GREEN_MIN, then 3.
    cycle(4'b1010, 4'b0000);
    n = 0;
    for (int c = 0; c < 40 && lights[11:9] != 3'b001; c++) begin
      cycle(4'b0000, 4'b0000);
      if (lights[5:3] == 3'b001) n++;
    end
    chk("rr_green1_len", 32'(n), 32'd4);
    chk("rr_green3",     32'(lights), 32'h324);
    chk("rr_active3",    32'(active_appr), 32'd3);

    // Max green: approach 0 keeps getting cars while 2 waits.
    cycle(4'b0101, 4'b0000);
    n = 0;
    for (int c = 0; c < 60 && lights[8:6] != 3'b001; c++) begin
      cycle(4'b0001, 4'b0000);
      if (lights[2:0] == 3'b001) n++;
    end
    chk("max_green0_len", 32'(n), 32'd12);
    chk("max_active2",    32'(active_appr), 32'd2);

    repeat (40) cycle(4'b0000, 4'b0000);
    chk("idle_active0", 32'(active_appr), 32'd0);
    chk("idle_lights",  32'(lights), 32'h921);
    chk("idle_queues",  32'(queue_count), 32'h0);

    // Emergency on the owner: straight to EM_GREEN, no yellow.
    cycle(4'b0000, 4'b0001);
    chk("emcur_lights",  32'(lights), 32'h921);
    chk("emcur_preempt", 32'(preempt_active), 32'd1);
    repeat (20) cycle(4'b0010, 4'b0001);
    chk("sat_q1", 32'(queue_count[7:4]), 32'd15);
    repeat (3) cycle(4'b0010, 4'b0001);
    chk("sat_q1_hold", 32'(queue_count[7:4]), 32'd15);
    cycle(4'b0001, 4'b0001);
    cycle(4'b0001, 4'b0001);
    chk("simul_q0", 32'(queue_count[3:0]), 32'd1);

    // Release: yellow, all-red with preempt held, then normal green on 1.
    cycle(4'b0000, 4'b0000);
    chk("rel_yellow0",   32'(lights), 32'h922);
    chk("rel_y_preempt", 32'(preempt_active), 32'd1);
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);
    chk("rel_allred",     32'(lights), 32'h924);
    chk("rel_ar_preempt", 32'(preempt_active), 32'd1);
    cycle(4'b0000, 4'b0000);
    chk("rel_green1",     32'(lights), 32'h90C);
    chk("rel_g_preempt",  32'(preempt_active), 32'd0);

    // Emergency on another approach early in green: GREEN_MIN ignored.
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0100);
    chk("pre_yellow1", 32'(lights), 32'h914);
    chk("pre_preempt", 32'(preempt_active), 32'd1);
    repeat (3) cycle(4'b0000, 4'b0100);
    chk("pre_emgreen2", 32'(lights), 32'h864);
    chk("pre_active2",  32'(active_appr), 32'd2);
    repeat (2) cycle(4'b0000, 4'b0100);
    cycle(4'b0000, 4'b0000);
    chk("pre_rel_yellow2", 32'(lights), 32'h8A4);
    chk("pre_rel_preempt", 32'(preempt_active), 32'd1);
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);
    chk("pre_rel_allred", 32'(lights), 32'h924);
    cycle(4'b0000, 4'b0000);
    chk("pre_rr_green1", 32'(lights), 32'h90C);

    // Two requests: lowest index (the owner, 1) wins, no yellow.
    cycle(4'b0000, 4'b0110);
    chk("conf_lights",  32'(lights), 32'h90C);
    chk("conf_preempt", 32'(preempt_active), 32'd1);
    chk("conf_active",  32'(active_appr), 32'd1);
    cycle(4'b0000, 4'b0110);
    repeat (4) cycle(4'b0000, 4'b0000);

    // Request dropped during all-red: normal arbitration, no EM_GREEN.
    cycle(4'b0000, 4'b1000);
    chk("drop_yellow1", 32'(lights), 32'h914);
    cycle(4'b0000, 4'b1000);
    cycle(4'b0000, 4'b1000);
    cycle(4'b0000, 4'b0000);
    chk("drop_green1",  32'(lights), 32'h90C);
    chk("drop_preempt", 32'(preempt_active), 32'd0);
    chk("drop_active",  32'(active_appr), 32'd1);

    // Asynchronous reset in the middle of green.
    repeat (2) cycle(4'b0000, 4'b0000);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_lights",  32'(lights), 32'h924);
    chk("mid_reset_queues",  32'(queue_count), 32'h0);
    chk("mid_reset_active",  32'(active_appr), 32'h0);
    chk("mid_reset_preempt", 32'(preempt_active), 32'h0);
    @(negedge clk) rst = 1'b1;
    cycle(4'b0000, 4'b0000);
    chk("mid_reset_boot", 32'(lights), 32'h921);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
